// File: rtl/aes_pkg.sv
// Shared constants, phase decode type and GF(2^8) helpers for the inverse round engine.
package aes_pkg;

    localparam logic [4:0]   KEY_FIRST  = 5'd0;
    localparam logic [4:0]   DATA_FIRST = 5'd4;
    localparam logic [4:0]   LAST       = 5'd19;

    // K10 of the all-ascending key 000102..0f, reloaded after the last round.
    localparam logic [127:0] K10_RELOAD = 128'hc5302b4d8ba707f3174a94e37f1d1113;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_KEY,
        PH_DATA
    } phase_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // a^254 by repeated squaring; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a  [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [7:0]  x2, x4, x8;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*i +: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_if.sv
// Round request / result bundle between the decrypt controller and aes_inv.
interface aes_inv_if;
    logic         enable;
    logic [127:0] i_text;
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] o_text;
    logic [127:0] Rkey;
    logic         done;

    modport master (output enable, i_text, key, round, input o_text, Rkey, done);
    modport slave  (input enable, i_text, key, round, output o_text, Rkey, done);
endinterface

// File: rtl/aes_sbox_dual.sv
// Forward / inverse AES S-box sharing one GF(2^8) inverter.
module aes_sbox_dual
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    input  logic       inv_i,
    output logic [7:0] byte_o
);
    logic [7:0] pre;
    logic [7:0] finv;
    logic [7:0] fwd;

    // Inverse path: inverse affine then field inverse; forward path: field inverse then affine.
    always_comb begin
        pre    = inv_i ? ({byte_i[6:0], byte_i[7]} ^ {byte_i[4:0], byte_i[7:5]} ^
                          {byte_i[1:0], byte_i[7:2]} ^ 8'h05)
                       : byte_i;
        finv   = gf_inv(pre);
        fwd    = finv ^ {finv[6:0], finv[7]} ^ {finv[5:0], finv[7:6]} ^
                 {finv[4:0], finv[7:5]} ^ {finv[3:0], finv[7:4]} ^ 8'h63;
        byte_o = inv_i ? finv : fwd;
    end
endmodule

// File: rtl/aes_inv.sv
// Byte-serial AES-128 inverse round: 4 key-schedule cycles then 16 data cycles.
module aes_inv
    import aes_pkg::*;
(
    input  logic     clock,
    input  logic     resetn,
    aes_inv_if.slave bus
);
    logic [4:0]   c_q, c_d;
    phase_t       phase;
    logic [3:0]   b;
    logic [1:0]   row, kcol, src_col, kbyte;
    logic [31:0]  t3;
    logic [7:0]   sbox_in, sbox_out;
    logic         sbox_inv;
    logic [127:0] dkey_d, dkey_q;
    logic [23:0]  sw_q, col_q;
    logic [31:0]  col_x, col_res;
    logic [95:0]  buf_q;
    logic [127:0] text_q, rkey_q;

    // Counter next state and phase decode; enable only matters while c is 0.
    always_comb begin
        c_d   = c_q + 5'd1;
        phase = (c_q < DATA_FIRST) ? PH_KEY : PH_DATA;
        if (c_q == KEY_FIRST) begin
            c_d   = bus.enable ? KEY_FIRST + 5'd1 : KEY_FIRST;
            phase = bus.enable ? PH_KEY : PH_IDLE;
        end else if (c_q == LAST) begin
            c_d = KEY_FIRST;
        end
    end

    // Pick this cycle's S-box operand: RotWord order of t3, or InvShiftRows source byte.
    always_comb begin
        b        = c_q[3:0] - DATA_FIRST[3:0];
        row      = b[1:0];
        kcol     = b[3:2];
        src_col  = kcol - row;
        kbyte    = c_q[1:0] + 2'd1;
        t3       = bus.key[127:96] ^ bus.key[95:64];
        sbox_inv = (c_q >= DATA_FIRST);
        sbox_in  = sbox_inv ? bus.i_text[{src_col, row, 3'b000} +: 8]
                            : t3[{kbyte, 3'b000} +: 8];
    end

    aes_sbox_dual u_sbox (
        .byte_i (sbox_in),
        .inv_i  (sbox_inv),
        .byte_o (sbox_out)
    );

    // Previous round key and the finished column (add key, then InvMixColumns unless last round).
    always_comb begin
        dkey_d  = {t3,
                   bus.key[95:64] ^ bus.key[63:32],
                   bus.key[63:32] ^ bus.key[31:0],
                   bus.key[31:0] ^ {sbox_out, sw_q} ^ {24'h0, rcon(bus.round)}};
        col_x   = {sbox_out, col_q} ^ dkey_q[{kcol, 5'b00000} +: 32];
        col_res = (bus.round != 4'd0) ? inv_mix_col(col_x) : col_x;
    end

    // Counter, SubWord/column byte capture, column buffer and result registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            c_q    <= KEY_FIRST;
            sw_q   <= '0;
            col_q  <= '0;
            dkey_q <= '0;
            buf_q  <= '0;
            text_q <= '0;
            rkey_q <= K10_RELOAD;
        end else if (phase != PH_IDLE) begin
            c_q <= c_d;
            if (phase == PH_KEY) begin
                if (c_q[1:0] == 2'd3) dkey_q <= dkey_d;
                else                  sw_q[{c_q[1:0], 3'b000} +: 8] <= sbox_out;
            end else if (row != 2'd3) begin
                col_q[{row, 3'b000} +: 8] <= sbox_out;
            end else if (kcol != 2'd3) begin
                buf_q[{kcol, 5'b00000} +: 32] <= col_res;
            end else begin
                text_q <= {col_res, buf_q};
                rkey_q <= (bus.round == 4'd0) ? K10_RELOAD : dkey_q;
            end
        end
    end

    assign bus.done   = (c_q == LAST);
    assign bus.o_text = text_q;
    assign bus.Rkey   = rkey_q;
endmodule

// File: tb/tb_aes_inv.sv
// Scoreboard bench for aes_inv: FIPS-197 vectors plus randomized rounds against a byte-level model.
module tb_aes_inv;
    localparam logic [127:0] K10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    aes_inv_if bus();
    aes_inv dut (.clock(clock), .resetn(resetn), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc[$];
    logic [127:0] exp_text_q[$];
    logic [127:0] exp_key_q[$];
    logic [127:0] last_text, last_key;
    logic [7:0] sb [256];
    logic [7:0] isb[256];
    logic [7:0] rc [10];

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic void model(input logic [127:0] txt, input logic [127:0] k, input logic [3:0] rnd,
                                  output logic [127:0] o, output logic [127:0] rk);
        logic [7:0] s[16], kb[16], nk[16], t[16], t3[4], tmp[4], a[4];
        for (int i = 0; i < 16; i++) begin
            s[i]  = txt[8*i +: 8];
            kb[i] = k[8*i +: 8];
        end
        for (int j = 0; j < 4; j++) t3[j] = kb[12+j] ^ kb[8+j];
        for (int j = 0; j < 4; j++) tmp[j] = sb[t3[(j+1)%4]];
        if (rnd < 10) tmp[0] = tmp[0] ^ rc[rnd];
        for (int j = 0; j < 4; j++) begin
            nk[j]    = kb[j] ^ tmp[j];
            nk[4+j]  = kb[4+j] ^ kb[j];
            nk[8+j]  = kb[8+j] ^ kb[4+j];
            nk[12+j] = t3[j];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = isb[s[4*((c - r + 4) % 4) + r]] ^ nk[4*c+r];
        if (rnd != 0) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = t[4*c+r];
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r+1)%4]) ^
                               gmul(8'h0d, a[(r+2)%4]) ^ gmul(8'h09, a[(r+3)%4]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8]  = t[i];
            rk[8*i +: 8] = nk[i];
        end
        if (rnd == 0) rk = K10;
    endfunction

    task automatic start_op(input logic [127:0] txt, input logic [127:0] k, input logic [3:0] rnd,
                            output logic [127:0] o, output logic [127:0] rk);
        model(txt, k, rnd, o, rk);
        bus.i_text = txt;
        bus.key    = k;
        bus.round  = rnd;
        bus.enable = 1'b1;
        exp_text_q.push_back(o);
        exp_key_q.push_back(rk);
    endtask

    // Called at the falling edge of a c=0 cycle; returns at the falling edge after the result lands.
    task automatic run_op(input logic [127:0] txt, input logic [127:0] k, input logic [3:0] rnd,
                          input bit toggle, input bit keep_en,
                          output logic [127:0] o, output logic [127:0] rk);
        start_op(txt, k, rnd, o, rk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i < 20 && toggle) bus.enable = 1'($urandom_range(0, 1));
        end
        bus.enable = keep_en;
    endtask

    // Monitor: counts done pulses and checks outputs on the cycle after each one.
    initial begin
        logic prev_done;
        logic [127:0] et, ek;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (prev_done) begin
                if (exp_text_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h with empty scoreboard", bus.o_text);
                end else begin
                    et = exp_text_q.pop_front();
                    ek = exp_key_q.pop_front();
                    chk("sb_o_text", bus.o_text, et);
                    chk("sb_Rkey", bus.Rkey, ek);
                    last_text = et;
                    last_key  = ek;
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            prev_done = (bus.done === 1'b1);
        end
    end

    initial begin
        logic [127:0] o, rk, st, k;
        logic [7:0] inv, c63;
        int d0, n0, t0;

        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                sb[x][i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

        resetn = 1'b1;
        bus.enable = 1'b0;
        bus.i_text = '0;
        bus.key    = '0;
        bus.round  = 4'd0;
        last_text  = '0;
        last_key   = K10;
        #2 resetn = 1'b0;
        #1;
        chk("rst_o_text", bus.o_text, 128'h0);
        chk("rst_Rkey", bus.Rkey, K10);
        chk("rst_done", {127'b0, bus.done}, 128'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // 1: round 9 vector
        t0 = cyc;
        run_op(bswap(128'h7ad5fda789ef4e272bca100b3d9ff59f), bswap(128'h13111d7fe3944a17f307a78b4d2b30c5),
               4'd9, 1'b0, 1'b0, o, rk);
        chk("t1_o_text", bus.o_text, bswap(128'h54d990a16ba09ab596bbf40ea111702f));
        chk("t1_Rkey", bus.Rkey, bswap(128'h549932d1f08557681093ed9cbe2c974e));
        chk("t1_done_latency", 128'(done_cyc[$] - t0), 128'd19);
        repeat (3) @(negedge clock);

        // 2: final round, no InvMixColumns, key reload
        run_op(bswap(128'h6353e08c0960e104cd70b751bacad0e7), bswap(128'hd6aa74fdd2af72fadaa678f1d6ab76fe),
               4'd0, 1'b0, 1'b0, o, rk);
        chk("t2_o_text", bus.o_text, bswap(128'h00112233445566778899aabbccddeeff));
        chk("t2_Rkey", bus.Rkey, K10);
        repeat (2) @(negedge clock);

        // 3: full ten-round decrypt, chained back to back
        d0 = done_cnt;
        n0 = done_cyc.size();
        st = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a) ^ K10;
        k  = K10;
        for (int r = 9; r >= 0; r--) run_op(st, k, 4'(r), 1'b0, (r != 0), st, k);
        chk("t3_plaintext", bus.o_text, bswap(128'h00112233445566778899aabbccddeeff));
        chk("t3_Rkey", bus.Rkey, K10);
        chk("t3_done_count", 128'(done_cnt - d0), 128'd10);
        for (int i = n0 + 1; i < done_cyc.size(); i++)
            chk("t3_done_spacing", 128'(done_cyc[i] - done_cyc[i-1]), 128'd20);
        repeat (2) @(negedge clock);

        // 4: enable held high, then toggled mid-operation
        n0 = done_cyc.size();
        for (int i = 0; i < 8; i++)
            run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                   4'($urandom_range(0, 15)), (i >= 4), 1'b1, o, rk);
        bus.enable = 1'b0;
        for (int i = n0 + 1; i < done_cyc.size(); i++)
            chk("t4_done_spacing", 128'(done_cyc[i] - done_cyc[i-1]), 128'd20);
        repeat (2) @(negedge clock);

        // 5: reset at c=10 aborts the operation
        start_op(bswap(128'h7ad5fda789ef4e272bca100b3d9ff59f), bswap(128'h13111d7fe3944a17f307a78b4d2b30c5),
                 4'd9, o, rk);
        repeat (10) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("t5_async_o_text", bus.o_text, 128'h0);
        chk("t5_async_Rkey", bus.Rkey, K10);
        chk("t5_async_done", {127'b0, bus.done}, 128'h0);
        exp_text_q.delete();
        exp_key_q.delete();
        bus.enable = 1'b0;
        d0 = done_cnt;
        @(negedge clock);
        resetn = 1'b1;
        repeat (25) @(negedge clock);
        chk("t5_no_done", 128'(done_cnt - d0), 128'd0);
        chk("t5_hold_o_text", bus.o_text, 128'h0);
        run_op(bswap(128'h7ad5fda789ef4e272bca100b3d9ff59f), bswap(128'h13111d7fe3944a17f307a78b4d2b30c5),
               4'd9, 1'b0, 1'b0, o, rk);
        chk("t5_restart_o_text", bus.o_text, bswap(128'h54d990a16ba09ab596bbf40ea111702f));
        chk("t5_restart_Rkey", bus.Rkey, bswap(128'h549932d1f08557681093ed9cbe2c974e));

        // 6: long idle holds outputs and never pulses done
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            chk("t6_idle_done", {127'b0, bus.done}, 128'h0);
            chk("t6_idle_o_text", bus.o_text, last_text);
            chk("t6_idle_Rkey", bus.Rkey, last_key);
        end
        t0 = cyc;
        run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               4'd5, 1'b0, 1'b0, o, rk);
        chk("t6_done_latency", 128'(done_cyc[$] - t0), 128'd19);

        // Randomized rounds with random gaps and mid-operation enable noise
        for (int i = 0; i < 12; i++) begin
            run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, o, rk);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        repeat (3) @(negedge clock);
        chk("sb_drained", 128'(exp_text_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
